reg6_hs_arbiter: RTL and testbench
==================================

// Module: reg6_hs_arbiter
// PURPOSE
//  Round-robin arbiter that shares one 6-bit handshake register among N_REQ requesters.
//  It grants one requester, drives the register's en/data_in, and waits for its 'fim'
//  completion flag. It then pulses an ack back to the winner and releases the register.
//  Sits between the requesting units and the register, which is the only consumer of reg_en/reg_data.
// PARAMETERS
//  N_REQ        4   number of requesters (2..8)
//  W            6   data width, equal to the register width
//  IDW          2   grant_id width, = clog2(N_REQ)
//  TIMEOUT_CYC  8   max cycles in WRITE before abort (only used with ARB_TIMEOUT_EN)
// PORTS
//  clk       in   1        rising-edge clock
//  rst_n     in   1        asynchronous reset, active-low
//  req       in   N_REQ    request per requester; hold high until ack
//  data_i    in   N_REQ*W  packed data, requester i in [i*W +: W]
//  ack       out  N_REQ    one-cycle completion pulse to the granted requester
//  grant_id  out  IDW      index of current/last granted requester
//  busy      out  1        high in every state except IDLE
//  reg_en    out  1        drives the register's en input
//  reg_data  out  W        drives the register's data_in input
//  reg_fim   in   1        the register's fim output
//  err       out  1        timeout pulse (tied 0 when ARB_TIMEOUT_EN is undefined)
// BEHAVIOUR
//  - All outputs are registered or Moore-decoded from the state; there is no combinational path from inputs to outputs.
//  - Reset (rst_n=0, asynchronous): state=IDLE, reg_en=0, reg_data=0, ack=0, grant_id=0,
//    busy=0, err=0, rr pointer=0, timeout counter=0. Reset mid-transaction aborts it and
//    emits no ack.
//  - FSM states: IDLE, WRITE, ACK, RELEASE (and ABORT with the macro).
//  - IDLE: reg_en=0. If |req, pick the first set bit at or after the rr pointer (wrapping
//    modulo N_REQ). Latch reg_data<=data_i[win], grant_id<=win, then go to WRITE.
//    If req is all-zero, stay in IDLE.
//  - WRITE: reg_en=1, reg_data held constant. If reg_fim=1, go to ACK.
//  - ACK: reg_en=0, ack[grant_id]=1 for exactly this cycle. rr pointer<=(grant_id+1)%N_REQ.
//    Next state is RELEASE.
//  - RELEASE: reg_en=0. Wait until reg_fim=0, then go to IDLE. This guarantees a stale fim
//    never completes the next grant.
//  - req is only sampled in IDLE. A requester dropping req after grant does not abort the
//    transaction; its ack is still pulsed. A req still high after ack is re-arbitrated
//    with the advanced pointer, so it has the lowest priority.
//  - Latency (register starts at 0): req sampled at edge k, then reg_en=1 after k, register
//    loads at k+1, fim=1 after k+2, ACK entered at k+3.
//    ack is therefore high in the cycle after edge k+3.
//    If the data already equals the register content, everything is one cycle earlier.
//  - Minimum spacing between two grants is 5 cycles.
// CONFIGURATION
//  ARB_TIMEOUT_EN defined:
//   - A counter clears on entry to WRITE and increments each WRITE cycle.
//   - If it reaches TIMEOUT_CYC with reg_fim=0, go to ABORT.
//   - ABORT: reg_en=0; err=1 and ack[grant_id]=1 for one cycle; rr pointer advances;
//     next state is RELEASE.
//   - reg_fim=1 in the same cycle as the count reaching TIMEOUT_CYC means success: go to ACK.
//  ARB_TIMEOUT_EN undefined: no counter; WRITE waits indefinitely; err is constant 0.
// TESTING
//  1. Reset with req=4'b0000, then release rst_n. Expect busy=0, reg_en=0, ack=0 for
//     10 cycles.
//  2. Single request: req=4'b0001, data0=6'h2A, register=0.
//     -> reg_data=6'h2A, reg_en=1 for 3 cycles, then ack=4'b0001 for 1 cycle.
//     -> register holds 6'h2A and grant_id=0.
//  3. Contention: req=4'b1111 held, data_i = 6'h01/02/03/04 for requesters 0..3.
//     -> ack order 0,1,2,3,0 with no repeat before wrap.
//     -> register values seen in order 01,02,03,04.
//  4. Same-data write: register=6'h15, requester 2 sends 6'h15.
//     -> ack[2] one cycle earlier than in test 2.
//     -> RELEASE waits for reg_fim=0 before the next grant.
//  5. Reset mid-op: assert rst_n=0 while in WRITE.
//     -> reg_en=0, busy=0 immediately (asynchronous), no ack pulse.
//     -> after release, the rr pointer restarts at 0.
//  6. (ARB_TIMEOUT_EN, TIMEOUT_CYC=8) Hold reg_fim stuck at 0.
//     -> after 8 WRITE cycles, err=1 and ack[grant_id]=1 for one cycle, then IDLE.
//     -> without the macro, busy stays 1 and reg_en stays 1.

Source files
------------

// File: rtl/reg6_hs_arbiter_if.sv
// Bundle of the requester-side and register-side signals of reg6_hs_arbiter.
// The arbiter uses the slave modport; the requesters plus the 6-bit register use master.
interface reg6_hs_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int W     = 6,
  parameter int IDW   = 2
);
  logic [N_REQ-1:0]   req;
  logic [N_REQ*W-1:0] data_i;
  logic [N_REQ-1:0]   ack;
  logic [IDW-1:0]     grant_id;
  logic               busy;
  logic               reg_en;
  logic [W-1:0]       reg_data;
  logic               reg_fim;
  logic               err;

  modport slave (
    input  req, data_i, reg_fim,
    output ack, grant_id, busy, reg_en, reg_data, err
  );

  modport master (
    output req, data_i, reg_fim,
    input  ack, grant_id, busy, reg_en, reg_data, err
  );
endinterface

// File: rtl/reg6_hs_arbiter.sv
// Round-robin arbiter sharing one 6-bit handshake register among N_REQ requesters.
// Define ARB_TIMEOUT_EN to abort a WRITE that sees no fim within TIMEOUT_CYC cycles.
module reg6_hs_arbiter #(
  parameter int N_REQ       = 4,
  parameter int W           = 6,
  parameter int IDW         = 2,
  parameter int TIMEOUT_CYC = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  reg6_hs_arbiter_if.slave   bus
);

`ifdef ARB_TIMEOUT_EN
  typedef enum logic [2:0] {IDLE, WRITE, ACK, RELEASE, ABORT} state_t;
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`else
  typedef enum logic [1:0] {IDLE, WRITE, ACK, RELEASE} state_t;
`endif

  state_t           state_q, state_d;
  logic             reg_en_q, reg_en_d;
  logic [W-1:0]     reg_data_q, reg_data_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [IDW-1:0]   grant_id_q, grant_id_d;
  logic             busy_q, busy_d;
  logic [IDW-1:0]   rr_q, rr_d;
  logic             found;
  logic [IDW-1:0]   win;
  logic [IDW-1:0]   next_rr;

  assign next_rr = IDW'((int'(grant_id_q) + 1) % N_REQ);

  // Search starts at the rr pointer so the last winner ends up with the lowest priority.
  always_comb begin
    found = 1'b0;
    win   = rr_q;
    for (int off = 0; off < N_REQ; off++) begin
      if (!found && bus.req[(int'(rr_q) + off) % N_REQ]) begin
        found = 1'b1;
        win   = IDW'((int'(rr_q) + off) % N_REQ);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    reg_data_d = reg_data_q;
    ack_d      = '0;
    grant_id_d = grant_id_q;
    rr_d       = rr_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d      = cnt_q;
    err_d      = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d    = WRITE;
          reg_data_d = bus.data_i[int'(win)*W +: W];
          grant_id_d = win;
`ifdef ARB_TIMEOUT_EN
          cnt_d      = '0;
`endif
        end
      end
      WRITE: begin
        if (bus.reg_fim) begin
          state_d = ACK;
          ack_d   = N_REQ'(1) << grant_id_q;
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          state_d = ABORT;
          ack_d   = N_REQ'(1) << grant_id_q;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ACK: begin
        state_d = RELEASE;
        rr_d    = next_rr;
      end
`ifdef ARB_TIMEOUT_EN
      ABORT: begin
        state_d = RELEASE;
        rr_d    = next_rr;
      end
`endif
      // A fim left high from the finished write must drop before the next grant.
      RELEASE: begin
        if (!bus.reg_fim) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    reg_en_d = (state_d == WRITE);
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      reg_en_q   <= 1'b0;
      reg_data_q <= '0;
      ack_q      <= '0;
      grant_id_q <= '0;
      busy_q     <= 1'b0;
      rr_q       <= '0;
`ifdef ARB_TIMEOUT_EN
      cnt_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      reg_en_q   <= reg_en_d;
      reg_data_q <= reg_data_d;
      ack_q      <= ack_d;
      grant_id_q <= grant_id_d;
      busy_q     <= busy_d;
      rr_q       <= rr_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q      <= cnt_d;
      err_q      <= err_d;
`endif
    end
  end

  assign bus.reg_en   = reg_en_q;
  assign bus.reg_data = reg_data_q;
  assign bus.ack      = ack_q;
  assign bus.grant_id = grant_id_q;
  assign bus.busy     = busy_q;
`ifdef ARB_TIMEOUT_EN
  assign bus.err      = err_q;
`else
  assign bus.err      = 1'b0;
`endif

endmodule

// File: tb/tb_reg6_hs_arbiter.sv
// Directed scoreboard bench for reg6_hs_arbiter with a behavioural 6-bit handshake register.
// Covers ARB_TIMEOUT_EN in both builds.
module tb_reg6_hs_arbiter;
  localparam int N_REQ = 4;
  localparam int W     = 6;
  localparam int IDW   = 2;

  typedef struct {
    logic [N_REQ-1:0] ack;
    logic [IDW-1:0]   id;
    logic [W-1:0]     data;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] reg_q = '0;
  logic         fim_r = 1'b0;
  logic         fim_hold;
  logic         fim_stuck;
  logic         preset_en;
  logic [W-1:0] preset_val;
  exp_t         exp_q[$];
  int           lat;
  int           en_cyc;

  reg6_hs_arbiter_if #(.N_REQ(N_REQ), .W(W), .IDW(IDW)) bus ();

  reg6_hs_arbiter #(.N_REQ(N_REQ), .W(W), .IDW(IDW), .TIMEOUT_CYC(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Register model: loads on en, raises fim one edge after its content matches data_in.
  assign bus.reg_fim = (fim_r | fim_hold) & ~fim_stuck;

  always @(posedge clk) begin
    fim_r <= bus.reg_en && (reg_q == bus.reg_data);
    if (preset_en)       reg_q <= preset_val;
    else if (bus.reg_en) reg_q <= bus.reg_data;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Every ack pulse must match the oldest outstanding expected grant.
  always @(negedge clk) begin
    exp_t e;
    if (bus.ack !== '0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("[TB] FAIL unexpected_ack: observed 0x%0h expected 0x0", bus.ack);
      end else begin
        e = exp_q.pop_front();
        checkOutput("sb_ack", 32'(bus.ack), 32'(e.ack));
        checkOutput("sb_grant_id", 32'(bus.grant_id), 32'(e.id));
        checkOutput("sb_reg_value", 32'(reg_q), 32'(e.data));
      end
    end
  end

  task automatic applyStimulus(input logic [N_REQ-1:0] r, input int id, input logic [W-1:0] d);
    bus.data_i[id*W +: W] = d;
    bus.req = r;
  endtask

  task automatic expectGrant(input int id, input logic [W-1:0] d);
    exp_t e;
    e.ack  = N_REQ'(1) << id;
    e.id   = IDW'(id);
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic waitAck(input int max_cyc, output int l, output int en);
    l  = 0;
    en = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      l++;
      if (bus.reg_en) en++;
      if (bus.ack !== '0) return;
    end
    checks++;
    errors++;
    $error("[TB] FAIL ack_timeout: observed no ack expected ack within %0d cycles", max_cyc);
  endtask

  task automatic waitIdle(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (!bus.busy) return;
    end
    checks++;
    errors++;
    $error("[TB] FAIL idle_timeout: observed busy=1 expected busy=0 within %0d cycles", max_cyc);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n   = 1'b0;
    bus.req = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n      = 1'b0;
    bus.req    = '0;
    bus.data_i = '0;
    fim_hold   = 1'b0;
    fim_stuck  = 1'b0;
    preset_en  = 1'b0;
    preset_val = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", 32'(bus.busy), 0);
    checkOutput("rst_reg_en", 32'(bus.reg_en), 0);
    checkOutput("rst_ack", 32'(bus.ack), 0);
    checkOutput("rst_grant_id", 32'(bus.grant_id), 0);
    checkOutput("rst_reg_data", 32'(bus.reg_data), 0);
    checkOutput("rst_err", 32'(bus.err), 0);

    $display("[TB] idle after reset");
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("idle_busy", 32'(bus.busy), 0);
      checkOutput("idle_reg_en", 32'(bus.reg_en), 0);
      checkOutput("idle_ack", 32'(bus.ack), 0);
    end

    $display("[TB] single request");
    applyStimulus(4'b0001, 0, 6'h2A);
    expectGrant(0, 6'h2A);
    waitAck(20, lat, en_cyc);
    bus.req = '0;
    checkOutput("single_latency", 32'(lat), 4);
    checkOutput("single_en_cycles", 32'(en_cyc), 3);
    checkOutput("single_reg_data", 32'(bus.reg_data), 32'h2A);
    checkOutput("single_reg_value", 32'(reg_q), 32'h2A);
    @(negedge clk);
    checkOutput("single_ack_pulse", 32'(bus.ack), 0);
    waitIdle(20);

    $display("[TB] contention");
    doReset();
    bus.data_i = {6'h04, 6'h03, 6'h02, 6'h01};
    bus.req    = 4'b1111;
    expectGrant(0, 6'h01);
    expectGrant(1, 6'h02);
    expectGrant(2, 6'h03);
    expectGrant(3, 6'h04);
    expectGrant(0, 6'h01);
    for (int g = 0; g < 5; g++) begin
      waitAck(20, lat, en_cyc);
      checkOutput("contention_spacing", 32'(lat), (g == 0) ? 32'd4 : 32'd6);
    end
    bus.req = '0;
    waitIdle(20);

    $display("[TB] same-data write and stale fim");
    @(negedge clk);
    preset_en  = 1'b1;
    preset_val = 6'h15;
    @(negedge clk);
    preset_en = 1'b0;
    applyStimulus(4'b0100, 2, 6'h15);
    expectGrant(2, 6'h15);
    waitAck(20, lat, en_cyc);
    checkOutput("same_data_latency", 32'(lat), 3);
    fim_hold = 1'b1;
    bus.req  = '0;
    applyStimulus(4'b0001, 0, 6'h2A);
    expectGrant(0, 6'h2A);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("release_busy", 32'(bus.busy), 1);
      checkOutput("release_reg_en", 32'(bus.reg_en), 0);
    end
    fim_hold = 1'b0;
    waitAck(20, lat, en_cyc);
    bus.req = '0;
    checkOutput("release_latency", 32'(lat), 5);
    waitIdle(20);

    $display("[TB] reset mid-operation");
    applyStimulus(4'b0010, 1, 6'h3F);
    for (int i = 0; i < 10 && !bus.reg_en; i++) @(negedge clk);
    checkOutput("midop_reg_en_seen", 32'(bus.reg_en), 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midop_reg_en", 32'(bus.reg_en), 0);
    checkOutput("midop_busy", 32'(bus.busy), 0);
    checkOutput("midop_ack", 32'(bus.ack), 0);
    checkOutput("midop_grant_id", 32'(bus.grant_id), 0);
    bus.req = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(4'b0011, 0, 6'h0C);
    expectGrant(0, 6'h0C);
    waitAck(20, lat, en_cyc);
    bus.req = '0;
    checkOutput("midop_restart_latency", 32'(lat), 4);
    waitIdle(20);

    $display("[TB] fim stuck low");
    fim_stuck = 1'b1;
    applyStimulus(4'b1000, 3, 6'h11);
`ifdef ARB_TIMEOUT_EN
    expectGrant(3, 6'h11);
    waitAck(30, lat, en_cyc);
    bus.req = '0;
    checkOutput("timeout_latency", 32'(lat), 9);
    checkOutput("timeout_en_cycles", 32'(en_cyc), 8);
    checkOutput("timeout_err", 32'(bus.err), 1);
    @(negedge clk);
    checkOutput("timeout_err_pulse", 32'(bus.err), 0);
    checkOutput("timeout_ack_pulse", 32'(bus.ack), 0);
    waitIdle(20);
    checkOutput("timeout_idle", 32'(bus.busy), 0);
    fim_stuck = 1'b0;
`else
    repeat (20) @(negedge clk);
    checkOutput("stuck_busy", 32'(bus.busy), 1);
    checkOutput("stuck_reg_en", 32'(bus.reg_en), 1);
    checkOutput("stuck_err", 32'(bus.err), 0);
    checkOutput("stuck_grant_id", 32'(bus.grant_id), 3);
    checkOutput("stuck_reg_data", 32'(bus.reg_data), 32'h11);
    doReset();
    fim_stuck = 1'b0;
`endif

    @(negedge clk);
    checkOutput("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
